// File: rtl/pc_seq.sv
// pc_seq: program-counter sequencer for the multicycle datapath.
// Holds the PC, the registered ALU result and the exception PC, and adds a
// circular return-address stack, a trap vector with return-from-trap, and
// fault detection for misaligned targets and RAS underflow.
module pc_seq #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned RESET_PC  = 0,
    parameter int unsigned TRAP_VEC  = 'h80,
    parameter int unsigned ALIGN     = 2,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_PCen,
    input  logic             i_IorD,
    input  logic [2:0]       i_PCsrc,
    input  logic             i_Push,
    input  logic [WIDTH-1:0] i_ALUresult,
    input  logic [WIDTH-1:0] i_Imm,
    output logic [WIDTH-1:0] o_Address,
    output logic [WIDTH-1:0] o_ALUout,
    output logic [WIDTH-1:0] o_PC,
    output logic [WIDTH-1:0] o_EPC,
    output logic             o_Fault,
    output logic [1:0]       o_Cause,
    output logic             o_RASempty,
    output logic             o_RASfull
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_PC);
    localparam logic [WIDTH-1:0] TRAP   = WIDTH'(TRAP_VEC);
    localparam logic [WIDTH-1:0] ALIGN_MASK =
        (ALIGN == 0) ? '0 : WIDTH'((64'd1 << ALIGN) - 64'd1);
    localparam logic [CW-1:0] CNT_MAX = CW'(RAS_DEPTH);

    localparam logic [2:0] SRC_ALUREG = 3'b001;
    localparam logic [2:0] SRC_IMM    = 3'b010;
    localparam logic [2:0] SRC_POP    = 3'b011;
    localparam logic [2:0] SRC_TRAP   = 3'b100;
    localparam logic [2:0] SRC_EPC    = 3'b101;

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_alu;
    logic [WIDTH-1:0] r_epc;
    logic             r_fault;
    logic [1:0]       r_cause;
    logic [WIDTH-1:0] r_ras [RAS_DEPTH];
    logic [PW-1:0]    r_top;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH-1:0] w_target;
    logic             w_trap;
    logic             w_underflow;
    logic             w_misalign;
    logic             w_fault;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_pc_d;
    logic [WIDTH-1:0] w_epc_d;
    logic [1:0]       w_cause_d;
    logic [PW-1:0]    w_top_d;
    logic [CW-1:0]    w_cnt_d;
    logic             w_wr_en;
    logic [PW-1:0]    w_wr_idx;

    // Select the candidate next-PC; 11x falls back to the ALU result.
    always_comb begin
        case (i_PCsrc)
            SRC_ALUREG: w_target = r_alu;
            SRC_IMM:    w_target = i_Imm;
            SRC_POP:    w_target = r_ras[r_top];
            SRC_EPC:    w_target = r_epc;
            default:    w_target = i_ALUresult;
        endcase
    end

    // Fault detection, next PC/EPC/cause and RAS pointer/count updates.
    always_comb begin
        w_trap      = i_PCen && (i_PCsrc == SRC_TRAP);
        // Underflow wins over misalignment when both would apply.
        w_underflow = i_PCen && (i_PCsrc == SRC_POP) && (r_cnt == '0);
        w_misalign  = i_PCen && (i_PCsrc != SRC_TRAP) && !w_underflow &&
                      (|(w_target & ALIGN_MASK));
        w_fault     = w_underflow || w_misalign;
        w_push      = i_PCen && i_Push && !w_fault;
        w_pop       = i_PCen && (i_PCsrc == SRC_POP) && !w_fault;

        w_top_d  = r_top;
        w_cnt_d  = r_cnt;
        w_wr_en  = 1'b0;
        w_wr_idx = r_top;
        if (w_push && w_pop) begin
            // Replace the top in place: count and pointer stay put.
            w_wr_en = 1'b1;
        end else if (w_push) begin
            // When full the increment lands on the oldest slot and drops it.
            w_wr_en  = 1'b1;
            w_wr_idx = r_top + PW'(1);
            w_top_d  = r_top + PW'(1);
            w_cnt_d  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);
        end else if (w_pop) begin
            w_top_d = r_top - PW'(1);
            w_cnt_d = r_cnt - CW'(1);
        end

        if (!i_PCen) begin
            w_pc_d = r_pc;
        end else if (w_trap || w_fault) begin
            w_pc_d = TRAP;
        end else begin
            w_pc_d = w_target;
        end

        w_epc_d = (w_trap || w_fault) ? r_pc : r_epc;

        if (w_underflow) begin
            w_cause_d = 2'b10;
        end else if (w_misalign) begin
            w_cause_d = 2'b01;
        end else begin
            w_cause_d = r_cause;
        end
    end

    // Core state registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pc    <= RST_PC;
            r_alu   <= '0;
            r_epc   <= '0;
            r_fault <= 1'b0;
            r_cause <= 2'b00;
            r_top   <= '0;
            r_cnt   <= '0;
        end else begin
            r_pc    <= w_pc_d;
            r_alu   <= i_ALUresult;
            r_epc   <= w_epc_d;
            r_fault <= w_fault;
            r_cause <= w_cause_d;
            r_top   <= w_top_d;
            r_cnt   <= w_cnt_d;
        end
    end

    // Return-address storage; a push always records the pre-update PC.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_ras[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_ras[w_wr_idx] <= r_pc;
        end
    end

    assign o_Address  = i_IorD ? r_alu : r_pc;
    assign o_ALUout   = r_alu;
    assign o_PC       = r_pc;
    assign o_EPC      = r_epc;
    assign o_Fault    = r_fault;
    assign o_Cause    = r_cause;
    assign o_RASempty = (r_cnt == '0);
    assign o_RASfull  = (r_cnt == CNT_MAX);

endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: directed scenarios plus randomized stimulus for pc_seq, checked
// against a behavioural model that keeps the RAS as a bounded queue.
module tb_pc_seq;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] TRAP  = 32'h80;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_PCen = 1'b0;
    logic        i_IorD = 1'b0;
    logic [2:0]  i_PCsrc = 3'b000;
    logic        i_Push = 1'b0;
    logic [31:0] i_ALUresult = '0;
    logic [31:0] i_Imm = '0;
    logic [31:0] o_Address, o_ALUout, o_PC, o_EPC;
    logic        o_Fault;
    logic [1:0]  o_Cause;
    logic        o_RASempty, o_RASfull;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [31:0] m_pc, m_alu, m_epc;
    logic        m_fault;
    logic [1:0]  m_cause;
    logic [31:0] ras_q[$];

    pc_seq dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_PCen      (i_PCen),
        .i_IorD      (i_IorD),
        .i_PCsrc     (i_PCsrc),
        .i_Push      (i_Push),
        .i_ALUresult (i_ALUresult),
        .i_Imm       (i_Imm),
        .o_Address   (o_Address),
        .o_ALUout    (o_ALUout),
        .o_PC        (o_PC),
        .o_EPC       (o_EPC),
        .o_Fault     (o_Fault),
        .o_Cause     (o_Cause),
        .o_RASempty  (o_RASempty),
        .o_RASfull   (o_RASfull)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_alu   = 32'h0;
        m_epc   = 32'h0;
        m_fault = 1'b0;
        m_cause = 2'b00;
        ras_q.delete();
    endtask

    task automatic model_push(input logic [31:0] v);
        if (ras_q.size() == DEPTH) void'(ras_q.pop_front());
        ras_q.push_back(v);
    endtask

    task automatic check_model();
        check_eq("pc", o_PC, m_pc);
        check_eq("aluout", o_ALUout, m_alu);
        check_eq("epc", o_EPC, m_epc);
        check_eq("fault", 32'(o_Fault), 32'(m_fault));
        check_eq("cause", 32'(o_Cause), 32'(m_cause));
        check_eq("address", o_Address, i_IorD ? m_alu : m_pc);
        check_eq("empty", 32'(o_RASempty), 32'(ras_q.size() == 0));
        check_eq("full", 32'(o_RASfull), 32'(ras_q.size() == DEPTH));
    endtask

    // One clock cycle of the model, from the inputs currently driven.
    task automatic model_update();
        logic [31:0] tgt, top;
        logic        under, mis;
        m_fault = 1'b0;
        if (i_PCen) begin
            case (i_PCsrc)
                3'd1:    tgt = m_alu;
                3'd2:    tgt = i_Imm;
                3'd3:    tgt = (ras_q.size() > 0) ? ras_q[$] : 32'h0;
                3'd5:    tgt = m_epc;
                default: tgt = i_ALUresult;
            endcase
            if (i_PCsrc == 3'd4) begin
                if (i_Push) model_push(m_pc);
                m_epc = m_pc;
                m_pc  = TRAP;
            end else begin
                under = (i_PCsrc == 3'd3) && (ras_q.size() == 0);
                mis   = (tgt % 4) != 0;
                if (under || mis) begin
                    m_fault = 1'b1;
                    m_cause = under ? 2'b10 : 2'b01;
                    m_epc   = m_pc;
                    m_pc    = TRAP;
                end else begin
                    if (i_PCsrc == 3'd3) begin
                        top = ras_q.pop_back();
                        tgt = top;
                    end
                    if (i_Push) model_push(m_pc);
                    m_pc = tgt;
                end
            end
        end
        m_alu = i_ALUresult;
    endtask

    // Drive one cycle's inputs, check the current state, advance one edge.
    task automatic step(input logic pcen, input logic iord, input logic [2:0] src,
                        input logic push, input logic [31:0] alu, input logic [31:0] imm);
        i_PCen = pcen;
        i_IorD = iord;
        i_PCsrc = src;
        i_Push = push;
        i_ALUresult = alu;
        i_Imm = imm;
        #1;
        check_model();
        model_update();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        logic [31:0] ra, rm;
        model_reset();
        // Asynchronous reset before any clock edge.
        #2 i_reset = 1'b1;
        #1;
        check_eq("rst_pc", o_PC, 32'h0);
        check_eq("rst_empty", 32'(o_RASempty), 32'd1);
        check_model();
        #17 i_reset = 1'b0;

        // Basic update and ALU register latency.
        step(1, 0, 3'd0, 0, 32'h4, 32'h0);
        check_eq("first_pc", o_PC, 32'h4);
        check_eq("first_aluout", o_ALUout, 32'h4);

        // Three calls then three returns.
        step(1, 0, 3'd0, 0, 32'h0, 32'h0);
        step(1, 0, 3'd0, 1, 32'h100, 32'h0);
        step(1, 0, 3'd0, 1, 32'h200, 32'h0);
        step(1, 0, 3'd0, 1, 32'h300, 32'h0);
        step(1, 0, 3'd3, 0, 32'h0, 32'h0);
        check_eq("ret1", o_PC, 32'h200);
        step(1, 0, 3'd3, 0, 32'h0, 32'h0);
        check_eq("ret2", o_PC, 32'h100);
        step(1, 1, 3'd3, 0, 32'h0, 32'h0);
        check_eq("ret3", o_PC, 32'h0);
        check_eq("ret_empty", 32'(o_RASempty), 32'd1);

        // Overflow: five pushes into four entries, then five pops.
        step(1, 0, 3'd2, 0, 32'h0, 32'h10);
        for (int i = 1; i <= 5; i++) step(1, 0, 3'd2, 1, 32'h0, 32'(16 * (i + 1)));
        check_eq("ovf_full", 32'(o_RASfull), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 3'd3, 0, 32'h0, 32'h0);
            check_eq("ovf_pop", o_PC, 32'(16 * (5 - i)));
        end
        step(1, 0, 3'd3, 0, 32'h0, 32'h0);
        check_eq("udf_pc", o_PC, TRAP);
        check_eq("udf_cause", 32'(o_Cause), 32'd2);
        check_eq("udf_fault", 32'(o_Fault), 32'd1);
        step(0, 0, 3'd0, 0, 32'h0, 32'h0);
        check_eq("udf_pulse", 32'(o_Fault), 32'd0);

        // Misaligned jump, then return from trap.
        step(1, 0, 3'd2, 0, 32'h0, 32'h40);
        step(1, 0, 3'd2, 0, 32'h0, 32'h102);
        check_eq("mis_pc", o_PC, TRAP);
        check_eq("mis_epc", o_EPC, 32'h40);
        check_eq("mis_cause", 32'(o_Cause), 32'd1);
        step(1, 0, 3'd5, 0, 32'h0, 32'h0);
        check_eq("rft_pc", o_PC, 32'h40);
        check_eq("rft_fault", 32'(o_Fault), 32'd0);

        // Push and pop together, then a disabled trap.
        step(1, 0, 3'd2, 0, 32'h0, 32'h30);
        step(1, 0, 3'd2, 1, 32'h0, 32'h60);
        step(1, 0, 3'd3, 1, 32'h0, 32'h0);
        check_eq("pp_pc", o_PC, 32'h30);
        check_eq("pp_empty", 32'(o_RASempty), 32'd0);
        step(0, 0, 3'd4, 1, 32'h0, 32'h0);
        check_eq("hold_pc", o_PC, 32'h30);
        check_eq("hold_epc", o_EPC, 32'h40);
        step(1, 0, 3'd3, 0, 32'h0, 32'h0);
        check_eq("pp_top", o_PC, 32'h60);

        // Reset mid-cycle, between edges.
        step(1, 0, 3'd4, 1, 32'h0, 32'h0);
        #2 i_reset = 1'b1;
        #1;
        check_eq("mid_rst_pc", o_PC, 32'h0);
        check_eq("mid_rst_empty", 32'(o_RASempty), 32'd1);
        model_reset();
        #3 i_reset = 1'b0;

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            ra = ($urandom_range(0, 5) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            rm = ($urandom_range(0, 5) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            step(($urandom_range(0, 4) != 0), 1'($urandom), 3'($urandom),
                 ($urandom_range(0, 2) == 0), ra, rm);
        end
        #1;
        check_model();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_seq.md
# pc_seq

Parametrised program-counter sequencer for the multicycle datapath, sitting between the ALU and the memory address mux. It holds the PC, the registered ALU result, and an exception PC (EPC). It adds a return-address stack (RAS) for call/return, a trap vector with return-from-trap, and fault detection for misaligned targets and RAS underflow.

## Interface
Parameters:
- WIDTH, 32, datapath/PC width in bits.
- RESET_PC, 0, PC value after reset.
- TRAP_VEC, 'h80, PC loaded on trap or fault.
- ALIGN, 2, number of low target bits that must be zero; 0 disables the alignment check.
- RAS_DEPTH, 4, return-address stack entries; power of two, 2 or more.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_PCen  in  1  PC update enable.
- i_IorD  in  1  address select: 1 = registered ALU result, 0 = PC.
- i_PCsrc  in  3  next-PC source: 000 i_ALUresult, 001 ALU register, 010 i_Imm, 011 RAS pop, 100 trap, 101 EPC (return from trap), 11x treated as 000.
- i_Push  in  1  push return address; honoured only when i_PCen=1.
- i_ALUresult  in  WIDTH  ALU output.
- i_Imm  in  WIDTH  absolute jump target.
- o_Address  out  WIDTH  memory address, i_IorD ? ALU register : o_PC.
- o_ALUout  out  WIDTH  ALU register.
- o_PC  out  WIDTH  current PC.
- o_EPC  out  WIDTH  exception PC.
- o_Fault  out  1  one-cycle pulse on a hardware fault.
- o_Cause  out  2  last fault cause: 01 misaligned, 10 RAS underflow; held until the next fault.
- o_RASempty  out  1  RAS count == 0.
- o_RASfull  out  1  RAS count == RAS_DEPTH.

## Operation
- The ALU register loads i_ALUresult every cycle, regardless of i_PCen.
- With i_PCen=0, the PC, EPC, RAS, and o_Cause hold, and o_Fault is 0.
- With i_PCen=1, the target is selected by i_PCsrc:
  - 000: i_ALUresult.
  - 001: ALU register.
  - 010: i_Imm.
  - 011: RAS top.
  - 101: o_EPC.
  - 100: trap. EPC <= o_PC and PC <= TRAP_VEC. This is a software trap, so no o_Fault and o_Cause is unchanged.
- Fault check (sources other than 100):
  - Source 011 with the RAS empty is an underflow fault, cause 10.
  - Otherwise, a target with any of bits [ALIGN-1:0] set is a misalignment fault, cause 01. TRAP_VEC is never checked.
- On a fault:
  - PC <= TRAP_VEC, EPC <= o_PC, o_Fault=1 next cycle, o_Cause updated.
  - The RAS is unchanged: no pop and no push.
- With no fault, PC <= target.
- RAS push (i_Push=1, i_PCen=1, no fault) pushes the pre-update o_PC.
- RAS pop happens when source is 011 and there is no fault.
- Push and pop in the same cycle: PC <= old top, the top entry is overwritten with o_PC, and the count is unchanged.
- Push when full: the oldest entry is discarded (circular buffer), the new entry becomes top, and the count stays at RAS_DEPTH.
- Push combined with a trap (100) is allowed; the push happens, then the PC goes to TRAP_VEC.

## Timing
- All state updates on the rising edge of i_clk. o_Address, o_RASempty and o_RASfull are combinational from registered state.
- Reset, asynchronous and effective immediately:
  - o_PC=RESET_PC, o_ALUout=0, o_EPC=0, o_Fault=0, o_Cause=00.
  - RAS count=0 (o_RASempty=1, o_RASfull=0); RAS entries cleared to 0.
- Reset asserted mid-operation overrides any pending update in the same cycle.
- Latency:
  - PC source to o_PC: 1 cycle.
  - ALU result to o_ALUout: 1 cycle.
  - Source 001 therefore returns the ALU result from the previous cycle.
- o_Fault is high for exactly one cycle per faulting i_PCen cycle. Back-to-back faults give back-to-back pulses.
- The RAS pointer wraps modulo RAS_DEPTH. The count saturates at RAS_DEPTH and bottoms at 0.

## Test plan
- Reset then release, PCsrc=000, PCen=1, ALUresult=4 -> o_PC=0 during reset, 4 one cycle after; o_ALUout=4.
- Push with ALUresult 0x100/0x200/0x300 at PC 0x0, 0x100, 0x200 (3 calls), then 3 pops -> o_PC sequence 0x200, 0x100, 0x0; o_RASempty=1 after the last pop.
- RAS_DEPTH=4, 5 pushes of PCs 0x10..0x50, then 5 pops -> pops return 0x50, 0x40, 0x30, 0x20; the 5th pop faults: o_PC=0x80, o_Cause=10, one-cycle o_Fault.
- PCsrc=010, i_Imm=0x102 from PC 0x40 -> o_PC=0x80, o_EPC=0x40, o_Cause=01; then PCsrc=101 -> o_PC=0x40, no fault.
- Push+pop same cycle with top=0x30 at PC 0x60 -> o_PC=0x30, new top=0x60, count unchanged; PCen=0 with PCsrc=100 -> o_PC, o_EPC and RAS hold.
- Assert i_reset asynchronously between edges mid-sequence -> o_PC=RESET_PC and o_RASempty=1 immediately, without waiting for an edge.
